// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD character-write path:
// sequencer state, instruction word layout and the fixed message text.
package lcd_pkg;

    localparam int unsigned DB_W   = 10;
    localparam int unsigned STEP_W = 6;
    localparam int unsigned CNT_W  = 20;

    typedef enum logic [2:0] {
        POWER_WAIT,
        ISSUE,
        WAIT_DONE,
        GAP,
        FINISHED
    } seq_state_t;

    // Instruction word as seen by the Instruction stage: {RS, RW, D[7:0]}
    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_word_t;

    localparam logic [7:0] FUNC_SET   = 8'h28;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] LINE1_ADDR = 8'h80;
    localparam logic [7:0] LINE2_ADDR = 8'hC0;

    localparam logic [STEP_W-1:0] CLEAR_STEP  = 6'd3;
    localparam logic [STEP_W-1:0] LINE1_STEP  = 6'd4;
    localparam logic [STEP_W-1:0] LINE1_FIRST = 6'd5;
    localparam logic [STEP_W-1:0] LINE1_LAST  = 6'd20;
    localparam logic [STEP_W-1:0] LINE2_STEP  = 6'd21;
    localparam logic [STEP_W-1:0] LINE2_FIRST = 6'd22;
    localparam logic [STEP_W-1:0] LAST_STEP   = 6'd37;

    localparam logic [127:0] LINE1_TEXT = "FPGA LCD DEMO   ";
    localparam logic [127:0] LINE2_TEXT = "SPARTAN-3E      ";

    // Character idx of a 16-char string literal; idx 0 is the leftmost char.
    function automatic logic [7:0] text_char(input logic [127:0] text, input logic [3:0] idx);
        logic [6:0] lsb;
        lsb = {~idx, 3'b000};
        return text[lsb +: 8];
    endfunction

endpackage

// File: rtl/lcd_command_sequencer_if.sv
// Handshake between the command sequencer and the Instruction stage.
interface lcd_command_sequencer_if;
    import lcd_pkg::*;

    logic      next_instruction;
    lcd_word_t db;
    logic      done;

    modport master (output next_instruction, output db, input done);
    modport slave  (input next_instruction, input db, output done);

endinterface

// File: rtl/lcd_message_rom.sv
// Fixed 38-entry instruction list: LCD setup, then two lines of text,
// each preceded by its DDRAM address.
module lcd_message_rom
    import lcd_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    output lcd_word_t         db
);

    always_comb begin
        db.rs   = 1'b0;
        db.rw   = 1'b0;
        db.data = 8'h00;
        case (step)
            6'd0:       db.data = FUNC_SET;
            6'd1:       db.data = ENTRY_MODE;
            6'd2:       db.data = DISP_ON;
            CLEAR_STEP: db.data = CLEAR;
            LINE1_STEP: db.data = LINE1_ADDR;
            LINE2_STEP: db.data = LINE2_ADDR;
            default: begin
                if (step >= LINE1_FIRST && step <= LINE1_LAST) begin
                    db.rs   = 1'b1;
                    db.data = text_char(LINE1_TEXT, 4'(step - LINE1_FIRST));
                end else if (step >= LINE2_FIRST && step <= LAST_STEP) begin
                    db.rs   = 1'b1;
                    db.data = text_char(LINE2_TEXT, 4'(step - LINE2_FIRST));
                end
            end
        endcase
    end

endmodule

// File: rtl/lcd_command_sequencer.sv
// Steps through the LCD message ROM after the power-on delay, launching one
// instruction at a time and honouring the per-command execution gap.
module lcd_command_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES   = 750000,
    parameter int unsigned CMD_GAP_CYCLES   = 2000,
    parameter int unsigned CLEAR_GAP_CYCLES = 82000
) (
    input  logic                           clk,
    input  logic                           reset,
    lcd_command_sequencer_if.master        instr,
    output logic                           seq_done
);

    // A zero-length wait or gap still takes one cycle.
    localparam logic [CNT_W-1:0] POWER_TGT =
        (POWERUP_CYCLES == 0) ? CNT_W'(1) : CNT_W'(POWERUP_CYCLES);
    localparam logic [CNT_W-1:0] CMD_TGT =
        (CMD_GAP_CYCLES == 0) ? CNT_W'(1) : CNT_W'(CMD_GAP_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_TGT =
        (CLEAR_GAP_CYCLES == 0) ? CNT_W'(1) : CNT_W'(CLEAR_GAP_CYCLES);

    seq_state_t        state, state_nx;
    logic [STEP_W-1:0] step, step_nx;
    logic [CNT_W-1:0]  count, count_nx;
    logic              next_instr_nx;
    lcd_word_t         db_nx;
    logic              seq_done_nx;
    lcd_word_t         rom_word;

    // ROM is addressed by the next step so db lands together with the strobe.
    lcd_message_rom u_rom (
        .step (step_nx),
        .db   (rom_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= POWER_WAIT;
            step                   <= '0;
            count                  <= '0;
            instr.next_instruction <= 1'b0;
            instr.db               <= '0;
            seq_done               <= 1'b0;
        end else begin
            state                  <= state_nx;
            step                   <= step_nx;
            count                  <= count_nx;
            instr.next_instruction <= next_instr_nx;
            instr.db               <= db_nx;
            seq_done               <= seq_done_nx;
        end
    end

    // Power-on wait counts up from the reset value; gaps count down to zero.
    always_comb begin
        state_nx = state;
        step_nx  = step;
        count_nx = count;
        case (state)
            POWER_WAIT: begin
                if (count >= POWER_TGT) begin
                    state_nx = ISSUE;
                    step_nx  = '0;
                    count_nx = '0;
                end else begin
                    count_nx = count + CNT_W'(1);
                end
            end
            ISSUE: state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (instr.done) begin
                    state_nx = GAP;
                    count_nx = (step == CLEAR_STEP) ? CLEAR_TGT : CMD_TGT;
                end
            end
            GAP: begin
                if (count == '0) begin
                    if (step == LAST_STEP) begin
                        state_nx = FINISHED;
                    end else begin
                        state_nx = ISSUE;
                        step_nx  = step + STEP_W'(1);
                    end
                end else begin
                    count_nx = count - CNT_W'(1);
                end
            end
            FINISHED: state_nx = FINISHED;
            default:  state_nx = POWER_WAIT;
        endcase

        next_instr_nx = (state_nx == ISSUE);
        db_nx         = (state_nx == ISSUE) ? rom_word : instr.db;
        seq_done_nx   = (state_nx == FINISHED);
    end

endmodule

// File: tb/tb_lcd_command_sequencer.sv
// Directed bench for lcd_command_sequencer with shortened timing parameters
// and an Instruction-stage model that returns done 8 cycles after each strobe.
module tb_lcd_command_sequencer;

    logic clk;
    logic reset;
    logic seq_done;
    logic [9:0] db_w;
    int   n_tests;
    int   n_fail;
    int   cyc;

    lcd_command_sequencer_if bus ();

    lcd_command_sequencer #(
        .POWERUP_CYCLES   (20),
        .CMD_GAP_CYCLES   (5),
        .CLEAR_GAP_CYCLES (12)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (bus),
        .seq_done (seq_done)
    );

    assign db_w = bus.db;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] exp_word [38] = '{
        10'h028, 10'h006, 10'h00C, 10'h001, 10'h080,
        10'h246, 10'h250, 10'h247, 10'h241, 10'h220, 10'h24C, 10'h243, 10'h244,
        10'h220, 10'h244, 10'h245, 10'h24D, 10'h24F, 10'h220, 10'h220, 10'h220,
        10'h0C0,
        10'h253, 10'h250, 10'h241, 10'h252, 10'h254, 10'h241, 10'h24E, 10'h22D,
        10'h233, 10'h245, 10'h220, 10'h220, 10'h220, 10'h220, 10'h220, 10'h220
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expects reset to have just been released right after a clock edge.
    task automatic power_on();
        int strobes;
        strobes = 0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 9) bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            if (bus.next_instruction) strobes++;
        end
        check("power_quiet", 32'(strobes), 32'd0);
        tick();
        check("first_strobe", 32'(bus.next_instruction), 32'd1);
        check("first_db", 32'(db_w), 32'h028);
    endtask

    // Walks the sequence from the first strobe; aborts with reset at abort_step.
    task automatic run(input int abort_step);
        int strobes;
        int changed;
        int hold;
        int gap;
        int d;
        for (int k = 0; k < 38; k++) begin
            check($sformatf("db_step%0d", k), 32'(db_w), 32'(exp_word[k]));
            if (k == abort_step) begin
                tick();
                tick();
                tick();
                reset = 1'b0;
                #1;
                check("abort_next", 32'(bus.next_instruction), 32'd0);
                check("abort_db", 32'(db_w), 32'h000);
                check("abort_seq_done", 32'(seq_done), 32'd0);
                return;
            end
            hold = (k == 15) ? 200 : 7;
            strobes = 0;
            changed = 0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (bus.next_instruction) strobes++;
                if (db_w !== exp_word[k]) changed++;
            end
            check($sformatf("wait_strobes%0d", k), 32'(strobes), 32'd0);
            check($sformatf("wait_db_stable%0d", k), 32'(changed), 32'd0);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            d = cyc;
            gap = (k == 3) ? 13 : 6;
            for (int i = 0; i < 40; i++) begin
                if (k == 6 && i == 2) bus.done = 1'b1;
                tick();
                bus.done = 1'b0;
                if (bus.next_instruction || seq_done) break;
            end
            check($sformatf("gap%0d", k), 32'(cyc - d), 32'(gap));
            if (k == 37) begin
                check("seq_done_rise", 32'(seq_done), 32'd1);
                check("final_no_strobe", 32'(bus.next_instruction), 32'd0);
            end else begin
                check($sformatf("strobe%0d", k + 1), 32'(bus.next_instruction), 32'd1);
            end
        end
        strobes = 0;
        changed = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            if (bus.next_instruction) strobes++;
            if (!seq_done || db_w !== 10'h220) changed++;
        end
        check("finished_strobes", 32'(strobes), 32'd0);
        check("finished_hold", 32'(changed), 32'd0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b0;
        bus.done = 1'b0;
        tick();
        tick();
        tick();
        check("rst_next", 32'(bus.next_instruction), 32'd0);
        check("rst_db", 32'(db_w), 32'h000);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        reset = 1'b1;
        power_on();
        run(-1);

        // Restart and abort in the middle of the first text line.
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        power_on();
        run(10);
        tick();
        tick();
        check("held_next", 32'(bus.next_instruction), 32'd0);
        reset = 1'b1;
        power_on();
        check("restart_seq_done", 32'(seq_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
